// File: rtl/button_debounce.sv
// Push-button conditioner: two-flop synchroniser, counter-based debounce,
// clean level plus press / release / long-press one-cycle pulses.
module button_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned LONG_CYCLES     = 25000000,
   parameter bit          ACTIVE_LOW      = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic btn_level,
   output logic press,
   output logic release_pulse,
   output logic long_press
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HW = (LONG_CYCLES == 0) ? 1
                                          : $clog2(LONG_CYCLES + 1);
   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
   localparam bit            LONG_EN   = (LONG_CYCLES != 0);

   typedef enum logic [1:0] {
      RELEASED,
      PRESS_CHK,
      PRESSED,
      RELEASE_CHK
   } state_t;

   state_t        state, state_d;
   logic          sync1, sync2;
   logic          p;
   logic [DW-1:0] db_cnt, db_d;
   logic [HW-1:0] hold_cnt, hold_d;
   logic          long_fired, fired_d;
   logic          level_d, press_d, rel_d, long_d;

   // Reset to the idle pin level so reset never looks like a press.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= ACTIVE_LOW;
         sync2 <= ACTIVE_LOW;
      end else begin
         sync1 <= btn_in;
         sync2 <= sync1;
      end
   end

   assign p = sync2 ^ ACTIVE_LOW;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= RELEASED;
         db_cnt        <= '0;
         hold_cnt      <= '0;
         long_fired    <= 1'b0;
         btn_level     <= 1'b0;
         press         <= 1'b0;
         release_pulse <= 1'b0;
         long_press    <= 1'b0;
      end else begin
         state         <= state_d;
         db_cnt        <= db_d;
         hold_cnt      <= hold_d;
         long_fired    <= fired_d;
         btn_level     <= level_d;
         press         <= press_d;
         release_pulse <= rel_d;
         long_press    <= long_d;
      end
   end

   always_comb begin
      state_d = state;
      db_d    = db_cnt;
      hold_d  = hold_cnt;
      fired_d = long_fired;
      level_d = btn_level;
      press_d = 1'b0;
      rel_d   = 1'b0;
      long_d  = 1'b0;
      unique case (state)
         RELEASED: begin
            if (p) begin
               state_d = PRESS_CHK;
               db_d    = '0;
            end
         end
         PRESS_CHK: begin
            if (!p) begin
               state_d = RELEASED;
            end else if (db_cnt == DB_LAST) begin
               state_d = PRESSED;
               press_d = 1'b1;
               level_d = 1'b1;
               hold_d  = '0;
               fired_d = 1'b0;
            end else begin
               db_d = db_cnt + 1'b1;
            end
         end
         PRESSED: begin
            // A release beats a long press due on the same cycle.
            if (!p) begin
               state_d = RELEASE_CHK;
               db_d    = '0;
            end else if (LONG_EN && !long_fired) begin
               if (hold_cnt == HOLD_LAST) begin
                  long_d  = 1'b1;
                  fired_d = 1'b1;
               end else begin
                  hold_d = hold_cnt + 1'b1;
               end
            end
         end
         RELEASE_CHK: begin
            if (p) begin
               state_d = PRESSED;
            end else if (db_cnt == DB_LAST) begin
               state_d = RELEASED;
               rel_d   = 1'b1;
               level_d = 1'b0;
            end else begin
               db_d = db_cnt + 1'b1;
            end
         end
         default: state_d = RELEASED;
      endcase
   end

endmodule

// File: tb/tb_button_debounce.sv
// Randomised bench for button_debounce against a sliding-window
// reference model of the debounce and long-press rules.
module tb_button_debounce;

   localparam int D = 4;
   localparam int L = 10;

   logic clk = 1'b0;
   logic rst;
   logic btn_in;
   logic btn_level, press, release_pulse, long_press;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   button_debounce #(
      .DEBOUNCE_CYCLES(D),
      .LONG_CYCLES    (L),
      .ACTIVE_LOW     (1'b1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .btn_in       (btn_in),
      .btn_level    (btn_level),
      .press        (press),
      .release_pulse(release_pulse),
      .long_press   (long_press)
   );

   // Model: p is the pressed sense of the pin two edges ago; the
   // level flips once the last D+1 samples all disagree with it.
   bit rawq[2];
   bit win[$];
   bit m_level, m_press, m_rel, m_long, m_fired, m_prevp;
   int m_hold;

   task automatic model_reset();
      rawq[0] = 1'b1;
      rawq[1] = 1'b1;
      win.delete();
      repeat (D + 1) win.push_back(1'b0);
      m_level = 0;
      m_press = 0;
      m_rel   = 0;
      m_long  = 0;
      m_fired = 0;
      m_prevp = 0;
      m_hold  = 0;
   endtask

   task automatic model_edge(input bit raw);
      bit p;
      bit flip;
      p = !rawq[1];
      rawq[1] = rawq[0];
      rawq[0] = raw;
      void'(win.pop_front());
      win.push_back(p);
      flip = 1'b1;
      foreach (win[i]) if (win[i] == m_level) flip = 1'b0;
      m_press = 0;
      m_rel   = 0;
      m_long  = 0;
      if (flip) begin
         m_level = !m_level;
         if (m_level) begin
            m_press = 1;
            m_hold  = 0;
            m_fired = 0;
         end else begin
            m_rel = 1;
         end
      end else if (m_level && m_prevp && p && !m_fired) begin
         m_hold++;
         if (m_hold == L) begin
            m_long  = 1;
            m_fired = 1;
         end
      end
      m_prevp = p;
   endtask

   // Called at a negedge; returns at the following negedge.
   task automatic step(input bit b);
      btn_in = b;
      @(posedge clk);
      model_edge(b);
      @(negedge clk);
   endtask

   function automatic logic [3:0] outs();
      return {btn_level, press, release_pulse, long_press};
   endfunction

   function automatic logic [3:0] mexp();
      return {m_level, m_press, m_rel, m_long};
   endfunction

   task automatic test_reset();
      rst    = 1'b1;
      btn_in = 1'b1;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (outs() !== 4'b0000) begin
            failures++;
            $display("FAIL reset_hold obs=%b exp=0000", outs());
         end
      end
      rst = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step(1'b1);
         checks++;
         if (outs() !== mexp() || outs() !== 4'b0000) begin
            failures++;
            $display("FAIL reset_idle i=%0d obs=%b exp=0000", i, outs());
         end
      end
   endtask

   task automatic test_clean_press();
      int np   = 0;
      int nl   = 0;
      int pidx = -1;
      for (int i = 0; i < 12; i++) begin
         step(1'b0);
         checks++;
         if (outs() !== mexp()) begin
            failures++;
            $display("FAIL clean_model i=%0d obs=%b exp=%b",
                     i, outs(), mexp());
         end
         if (press) begin
            np++;
            pidx = i;
         end
         if (long_press) nl++;
      end
      checks++;
      if (np != 1 || pidx != D + 2) begin
         failures++;
         $display("FAIL clean_press n=%0d idx=%0d exp n=1 idx=%0d",
                  np, pidx, D + 2);
      end
      checks++;
      if (btn_level !== 1'b1 || nl != 0) begin
         failures++;
         $display("FAIL clean_level lvl=%b longs=%0d exp 1/0",
                  btn_level, nl);
      end
      for (int i = 0; i < 10; i++) begin
         step(1'b1);
         checks++;
         if (outs() !== mexp()) begin
            failures++;
            $display("FAIL clean_rel i=%0d obs=%b exp=%b",
                     i, outs(), mexp());
         end
      end
      checks++;
      if (btn_level !== 1'b0) begin
         failures++;
         $display("FAIL clean_idle lvl=%b exp=0", btn_level);
      end
   endtask

   task automatic test_bounce_reject();
      int glen[3];
      int act;
      glen[0] = 3;
      glen[1] = 1;
      glen[2] = int'($urandom_range(1, D));
      foreach (glen[g]) begin
         act = 0;
         for (int i = 0; i < glen[g] + 12; i++) begin
            step(i < glen[g] ? 1'b0 : 1'b1);
            checks++;
            if (outs() !== mexp()) begin
               failures++;
               $display("FAIL bounce_model g=%0d i=%0d obs=%b exp=%b",
                        glen[g], i, outs(), mexp());
            end
            if (outs() != 4'b0000) act++;
         end
         checks++;
         if (act != 0) begin
            failures++;
            $display("FAIL bounce_reject g=%0d active=%0d exp=0",
                     glen[g], act);
         end
      end
   endtask

   task automatic test_long_press();
      int pidx = -1;
      int lidx = -1;
      int nl   = 0;
      int ridx = -1;
      bit rlvl = 1'b1;
      for (int i = 0; i < 42; i++) begin
         step(i < 30 ? 1'b0 : 1'b1);
         checks++;
         if (outs() !== mexp()) begin
            failures++;
            $display("FAIL long_model i=%0d obs=%b exp=%b",
                     i, outs(), mexp());
         end
         if (press) pidx = i;
         if (long_press) begin
            nl++;
            lidx = i;
         end
         if (release_pulse) begin
            ridx = i - 30;
            rlvl = btn_level;
         end
      end
      checks++;
      if (pidx != D + 2 || lidx != D + 2 + L || nl != 1) begin
         failures++;
         $display("FAIL long_timing p=%0d l=%0d n=%0d exp %0d/%0d/1",
                  pidx, lidx, nl, D + 2, D + 2 + L);
      end
      checks++;
      if (ridx != D + 2 || rlvl !== 1'b0) begin
         failures++;
         $display("FAIL long_release idx=%0d lvl=%b exp %0d/0",
                  ridx, rlvl, D + 2);
      end
   endtask

   task automatic test_release_bounce();
      int g    = int'($urandom_range(1, D));
      int lidx = -1;
      int nr   = 0;
      int drop = 0;
      bit b;
      for (int i = 0; i < 9 + g + 25; i++) begin
         b = (i >= 9 && i < 9 + g);
         step(b);
         checks++;
         if (outs() !== mexp()) begin
            failures++;
            $display("FAIL rbounce_model g=%0d i=%0d obs=%b exp=%b",
                     g, i, outs(), mexp());
         end
         if (long_press) lidx = i;
         if (release_pulse) nr++;
         if (i > D + 2 && btn_level !== 1'b1) drop++;
      end
      checks++;
      if (nr != 0 || drop != 0) begin
         failures++;
         $display("FAIL rbounce_level rel=%0d drops=%0d exp 0/0",
                  nr, drop);
      end
      checks++;
      if (lidx != D + 2 + L + g + 1) begin
         failures++;
         $display("FAIL rbounce_long g=%0d idx=%0d exp=%0d",
                  g, lidx, D + 2 + L + g + 1);
      end
      for (int i = 0; i < 10; i++) step(1'b1);
   endtask

   task automatic test_reset_mid_press();
      int pidx = -1;
      for (int i = 0; i < 9; i++) step(1'b0);
      checks++;
      if (btn_level !== 1'b1) begin
         failures++;
         $display("FAIL midrst_pre lvl=%b exp=1", btn_level);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (outs() !== 4'b0000) begin
         failures++;
         $display("FAIL midrst_async obs=%b exp=0000", outs());
      end
      model_reset();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (outs() !== 4'b0000) begin
            failures++;
            $display("FAIL midrst_hold obs=%b exp=0000", outs());
         end
      end
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step(1'b0);
         checks++;
         if (outs() !== mexp()) begin
            failures++;
            $display("FAIL midrst_model i=%0d obs=%b exp=%b",
                     i, outs(), mexp());
         end
         if (press) pidx = i;
      end
      checks++;
      if (pidx != D + 2) begin
         failures++;
         $display("FAIL midrst_press idx=%0d exp=%0d", pidx, D + 2);
      end
      for (int i = 0; i < 10; i++) step(1'b1);
   endtask

   task automatic test_random();
      bit lvl = 1'b1;
      int run;
      int npul;
      bit prev = 1'b0;
      for (int r = 0; r < 60; r++) begin
         lvl = ($urandom_range(0, 3) == 0) ? lvl : !lvl;
         run = int'($urandom_range(1, 16));
         for (int i = 0; i < run; i++) begin
            step(lvl);
            checks++;
            if (outs() !== mexp()) begin
               failures++;
               $display("FAIL random_model r=%0d obs=%b exp=%b",
                        r, outs(), mexp());
            end
            npul = int'(press) + int'(release_pulse) + int'(long_press);
            checks++;
            if (npul > 1 || (prev && npul != 0)) begin
               failures++;
               $display("FAIL random_pulses n=%0d prev=%b exp excl",
                        npul, prev);
            end
            prev = (npul != 0);
         end
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce_reject();
      test_long_press();
      test_release_bounce();
      test_reset_mid_press();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
